// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide) with start/busy/done.
// Define MULDIV_FAST_MUL_EN to finish the multiply ops in one cycle on a combinational multiplier.
module muldiv_unit #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int unsigned W = DATA_WIDTH;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e       state_q, state_d;
   logic [2:0]   op_q, op_d;
   logic [W:0]   hi_q, hi_d;      // product high half / partial remainder
   logic [W-1:0] lo_q, lo_d;      // multiplier bits / dividend shifting into quotient
   logic [W-1:0] m_q, m_d;        // multiplicand / divisor magnitude
   logic [W-1:0] result_q, result_d;
   logic         neg_q, neg_d, rneg_q, rneg_d;
   logic [4:0]   cnt_q, cnt_d;

   logic         is_div, sgn1, sgn2, s1, s2, fast_hit;
   logic [W-1:0] mag1, mag2, fast_val, fix_val, quo, rem;
   logic [W:0]   shifted, diff, sum;
   logic [2*W-1:0] prod, prod_s;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*W-1:0] fa, fb, prod_fast;
   assign fa        = {{W{s1}}, op1};
   assign fb        = {{W{sgn2 & op2[W-1]}}, op2};
   assign prod_fast = fa * fb;
`endif

   always_comb begin
      is_div = op[2];
      sgn1   = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
      sgn2   = sgn1 && (op != 3'b010);
      s1     = sgn1 & op1[W-1];
      s2     = sgn2 & op2[W-1];
      mag1   = s1 ? -op1 : op1;
      mag2   = s2 ? -op2 : op2;

      fast_hit = 1'b0;
      fast_val = '0;
      if (is_div && op2 == '0) begin
         fast_hit = 1'b1;
         fast_val = op[1] ? op1 : '1;
      end else if (is_div && !op[0] && op1 == {1'b1, {(W-1){1'b0}}} && op2 == '1) begin
         fast_hit = 1'b1;
         fast_val = op[1] ? '0 : op1;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!is_div) begin
         fast_hit = 1'b1;
         // a 33x33 signed product; MULHSU zero-extends op2 via sgn2
         fast_val = (op == 3'b000) ? prod_fast[W-1:0] : prod_fast[2*W-1:W];
      end
`endif
   end

   // Sign correction and output-word selection applied in FIX.
   always_comb begin
      prod   = {hi_q[W-1:0], lo_q};
      prod_s = neg_q ? -prod : prod;
      quo    = neg_q ? -lo_q : lo_q;
      rem    = rneg_q ? -hi_q[W-1:0] : hi_q[W-1:0];
      case (op_q)
         3'b000:                fix_val = prod_s[W-1:0];
         3'b001, 3'b010, 3'b011: fix_val = prod_s[2*W-1:W];
         3'b100, 3'b101:        fix_val = quo;
         default:               fix_val = rem;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      m_d      = m_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      shifted  = {hi_q[W-1:0], lo_q[W-1]};
      diff     = shifted - {1'b0, m_q};
      sum      = hi_q + (lo_q[0] ? {1'b0, m_q} : '0);

      unique case (state_q)
         StIdle: begin
            if (start) begin
               op_d   = op;
               neg_d  = s1 ^ s2;
               rneg_d = s1;
               cnt_d  = 5'd31;
               hi_d   = '0;
               lo_d   = is_div ? mag1 : mag2;
               m_d    = is_div ? mag2 : mag1;
               if (fast_hit) begin
                  result_d = fast_val;
                  state_d  = StDone;
               end else begin
                  state_d  = StCalc;
               end
            end
         end
         StCalc: begin
            if (op_q[2]) begin
               if (shifted >= {1'b0, m_q}) begin
                  hi_d = diff;
                  lo_d = {lo_q[W-2:0], 1'b1};
               end else begin
                  hi_d = shifted;
                  lo_d = {lo_q[W-2:0], 1'b0};
               end
            end else begin
               hi_d = {1'b0, sum[W:1]};
               lo_d = {sum[0], lo_q[W-1:1]};
            end
            if (cnt_q == 5'd0) state_d = StFix;
            else               cnt_d   = cnt_q - 5'd1;
         end
         StFix: begin
            result_d = fix_val;
            state_d  = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (flush) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         m_q      <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         m_q      <= m_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: transaction-level reference model compared every cycle,
// directed RV32M cases with literal results, flush/reset/back-to-back scenarios, random ops.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit chk_en = 1'b0;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .op1(op1), .op2(op2),
      .flush(flush), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural RV32M result computed with plain integer arithmetic.
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      int ia = $signed(a);
      int ib = $signed(b);
      logic [63:0] p;
      logic [31:0] r;
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 0) ? a :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Edges after the accepting edge until done is shown (0 = done in the very next cycle).
   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
`ifdef MULDIV_FAST_MUL_EN
      if (!f[2]) return 0;
`endif
      return 33;
   endfunction

   // Reference model: tracks accepted ops as a countdown to the done cycle.
   int          m_left = 0;
   bit          m_in_done = 1'b0;
   logic [31:0] m_pending = '0;
   logic [31:0] m_result = '0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_left = 0; m_in_done = 1'b0; m_result = '0;
      end else if (flush) begin
         m_left = 0; m_in_done = 1'b0;
      end else if (m_in_done) begin
         m_in_done = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_in_done = 1'b1;
            m_result  = m_pending;
         end
      end else if (start) begin
         m_pending = ref_op(op, op1, op2);
         m_left    = ref_lat(op, op1, op2);
         if (m_left == 0) begin
            m_in_done = 1'b1;
            m_result  = m_pending;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_left > 0 || m_in_done));
         chk("done", 32'(done), 32'(m_in_done));
         chk("result", result, m_result);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Issue one op, scramble inputs after the accepting edge, check result and latency.
   task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat = 0;
      op = f; op1 = a; op2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
      @(negedge clk);
      while (!done && lat < 60) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      chk({name, "_result"}, result, exp);
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic run_rand();
      int k;
      bit do_fl;
      op = 3'($urandom_range(0, 7)); op1 = pick(); op2 = pick(); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op1 = $urandom; op2 = $urandom;
      do_fl = ($urandom_range(0, 4) == 0);
      k = $urandom_range(0, 40);
      for (int i = 0; i < k && busy; i++) begin
         @(posedge clk); #1;
      end
      if (do_fl && busy) begin
         flush = 1'b1;
         @(posedge clk); #1;
         flush = 1'b0;
      end
      wait_idle();
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int mul_lat;
      int dc;
`ifdef MULDIV_FAST_MUL_EN
      mul_lat = 0;
`else
      mul_lat = 33;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'h0);
      @(posedge clk); #1;

      do_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, mul_lat);
      do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, mul_lat);
      do_op("mulhu",  3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, mul_lat);
      do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, mul_lat);
      do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      do_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        33);
      do_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         33);
      do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        0);
      do_op("divu_z", 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
      do_op("rem_z",  3'd6, 32'd5,         32'd0,         32'd5,         0);

      // flush sampled at E0+10 of a DIV: idle next edge, no done, result kept
      dc = done_cnt;
      op = 3'd4; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      repeat (40) begin @(posedge clk); #1; end
      chk("flush_no_done", 32'(done_cnt - dc), 32'd0);
      chk("flush_result", result, 32'd5);

      // asynchronous reset mid-CALC
      op = 3'd5; op1 = 32'd1234; op2 = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_result", result, 32'h0);
      chk("async_rst_done", 32'(done), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // start held across three DIVU ops: accepts at E0, E0+35, E0+70
      dc = done_cnt;
      op = 3'd5; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
      repeat (71) begin @(posedge clk); #1; end
      start = 1'b0;
      wait_idle();
      @(posedge clk); #1;
      chk("b2b_done_pulses", 32'(done_cnt - dc), 32'd3);
      chk("b2b_result", result, 32'd142);

      for (int i = 0; i < 80; i++) run_rand();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
